pcm_tx_serializer: RTL and testbench
====================================

Name: pcm_tx_serializer

Overview:
- Downstream neighbour of the decoder output PCM stage: consumes the 8-bit companded sample SD (one per 125 us sample period) and transmits it serially on a TDM PCM highway.
- Buffers samples in a 2-entry FIFO and generates the frame-sync and bit counters from a bit-clock enable.
- Shifts the sample out MSB-first in a programmable timeslot.
- Inserts the law-dependent idle code on underrun and flags FIFO under/overflow.

Parameters:
- FRAME_SLOTS, 32, timeslots per frame (8 bits each); frame length = FRAME_SLOTS*8 bit periods; legal range 2..64.
- TX_SLOT, 0, timeslot index (0..FRAME_SLOTS-1) in which this channel drives the highway.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  system reset, asynchronous, active-low (0 = reset).
- SD  input  8  companded PCM sample from the output PCM stage.
- SD_VALID  input  1  SD is valid this cycle (push request).
- SD_READY  output  1  FIFO not full; a push is accepted when SD_VALID and SD_READY are both 1.
- LAW  input  1  0 = mu-law, 1 = A-law; selects the idle code.
- BCLK_EN  input  1  one-clk pulse per highway bit period.
- STAT_CLR  input  1  synchronous clear of the sticky flags.
- PCM_OUT  output  1  serial data, MSB first.
- PCM_OE  output  1  highway drive enable; 1 only during TX_SLOT.
- PCM_FS  output  1  frame sync.
- UNDERRUN  output  1  sticky: a slot started with the FIFO empty.
- OVERFLOW  output  1  sticky: a push was attempted while the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - Bit counter = FRAME_SLOTS*8-1.
  - FIFO empty, shift register = 0.
  - PCM_OUT=0, PCM_OE=0, PCM_FS=0, UNDERRUN=0, OVERFLOW=0.
  - SD_READY=1 (combinational !full).
- Bit counter: advances only on BCLK_EN and wraps from FRAME_SLOTS*8-1 to 0. The first BCLK_EN after reset yields position p=0.
- Output timing: all serial outputs are registered and update on the BCLK_EN cycle, reflecting the new position p.
- Frame sync: PCM_FS=1 while p==0 (one bit period wide), else 0.
- Slot start, p==TX_SLOT*8:
  - FIFO non-empty: pop the head into an 8-bit shift register.
  - FIFO empty: load the idle code (LAW=0 -> 8'hFF, LAW=1 -> 8'hD5, LAW sampled that cycle) and set UNDERRUN.
  - PCM_OUT = bit 7 of the loaded value; PCM_OE=1.
- Within the slot, p = TX_SLOT*8+1 .. TX_SLOT*8+7: on each BCLK_EN, shift left and PCM_OUT = next bit. PCM_OE stays 1.
- At p == TX_SLOT*8+8 (mod frame length): PCM_OE=0, PCM_OUT=0. Both stay 0 outside the slot.
- Between BCLK_EN pulses, all outputs hold.
- FIFO: 2 entries, first-in first-out.
  - Push and pop in the same cycle: both take effect; occupancy is unchanged; the popped value is the older entry.
  - Push with FIFO empty and a slot-start pop in the same cycle: the pop sees empty, so the idle code is sent, UNDERRUN is set, and the pushed sample is stored (occupancy 1).
  - SD_VALID while full: sample dropped and OVERFLOW set, even if a pop occurs in the same cycle (SD_READY was 0).
- Sticky flags: STAT_CLR=1 clears UNDERRUN/OVERFLOW next cycle. If a set event coincides with STAT_CLR, the set wins.
- Reset mid-slot: outputs return to reset values immediately. The partially sent sample and FIFO contents are discarded. The counter restarts so that the next BCLK_EN gives p=0.
- Latency: a sample pushed before the slot-start BCLK_EN appears on PCM_OUT at that slot start. Its MSB is visible the clk after the slot-start BCLK_EN.

Optional Feature:
- Macro: PCM_TX_LONG_FS_EN.
- Defined: long frame sync. PCM_FS=1 for positions 0..7 (the whole of slot 0, 8 bit periods) and 0 otherwise.
- Undefined: short frame sync. PCM_FS=1 only at p==0 (one bit period).
- All other behaviour is identical.

Test Plan:
- Basic slot: FRAME_SLOTS=4, TX_SLOT=1; push SD=8'hA5 before the frame.
  - PCM_OE=1 for p=8..15; PCM_OUT sequence 1,0,1,0,0,1,0,1.
  - PCM_FS=1 only at p=0; OE=0 elsewhere; no flags set.
- Underrun idle:
  - No push, LAW=1: slot sends 8'hD5 (1,1,0,1,0,1,0,1) and UNDERRUN=1.
  - Repeat with LAW=0: sends 8'hFF.
  - Pulse STAT_CLR: UNDERRUN=0 next cycle.
- Overflow:
  - Push 8'h11, 8'h22 (SD_READY goes 0), then a push of 8'h33 with SD_VALID=1: OVERFLOW=1.
  - Next two frames transmit 8'h11, then 8'h22; 8'h33 never appears.
- Simultaneous push/pop on a full FIFO at slot start:
  - 8'h11 sent; 8'h44 dropped; OVERFLOW=1; occupancy 1 (8'h22).
  - Push into an empty FIFO at slot start: idle code sent, UNDERRUN=1, sample sent in the next frame.
- Reset mid-slot: assert reset at p=11.
  - PCM_OE/PCM_OUT/PCM_FS drop to 0 asynchronously and the FIFO empties.
  - After release, the first BCLK_EN gives PCM_FS=1 (p=0).
- Long FS (PCM_TX_LONG_FS_EN defined): PCM_FS=1 for exactly 8 BCLK_EN periods starting at p=0, every frame.

Source files
------------

// File: rtl/pcm_tx_serializer.sv
// TDM PCM highway transmitter: 2-entry sample FIFO, frame/bit counter, MSB-first slot serializer.
// Define PCM_TX_LONG_FS_EN for a long (slot-0 wide) frame sync; default is a one-bit-period sync.
module pcm_tx_serializer #(
  parameter int unsigned FRAME_SLOTS = 32,
  parameter int unsigned TX_SLOT     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] SD,
  input  logic       SD_VALID,
  output logic       SD_READY,
  input  logic       LAW,
  input  logic       BCLK_EN,
  input  logic       STAT_CLR,
  output logic       PCM_OUT,
  output logic       PCM_OE,
  output logic       PCM_FS,
  output logic       UNDERRUN,
  output logic       OVERFLOW
);

  localparam int unsigned FrameLen = FRAME_SLOTS * 8;
  localparam int unsigned CntW     = $clog2(FrameLen);

  localparam logic [CntW-1:0] LastPos   = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] SlotStart = CntW'(TX_SLOT * 8);
  localparam logic [CntW-1:0] SlotBits  = CntW'(8);
  localparam logic [7:0]      IdleMu    = 8'hFF;
  localparam logic [7:0]      IdleA     = 8'hD5;

  // Frame position counter
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] pos_next;
  logic [CntW-1:0] slot_offset;
  logic            slot_start;
  logic            in_slot;

  // Sample FIFO
  logic [7:0] mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  // Serializer and status
  logic [7:0] shift_q, shift_d;
  logic       out_q, out_d;
  logic       oe_q, oe_d;
  logic       fs_q, fs_d;
  logic       underrun_q, underrun_d;
  logic       overflow_q, overflow_d;
  logic       fs_pos;

  always_comb begin
    pos_next    = (bit_cnt_q == LastPos) ? '0 : bit_cnt_q + CntW'(1);
    bit_cnt_d   = BCLK_EN ? pos_next : bit_cnt_q;
    // Modular offset keeps the slot test free of a lower-bound compare against zero.
    slot_offset = pos_next - SlotStart;
    in_slot     = slot_offset < SlotBits;
    slot_start  = BCLK_EN && (pos_next == SlotStart);
  end

`ifdef PCM_TX_LONG_FS_EN
  assign fs_pos = pos_next < SlotBits;
`else
  assign fs_pos = pos_next == '0;
`endif

  assign full     = count_q == 2'd2;
  assign empty    = count_q == 2'd0;
  assign SD_READY = !full;
  // Pop decision uses the pre-push occupancy, so a same-cycle push into an empty FIFO underruns.
  assign push     = SD_VALID && !full;
  assign pop      = slot_start && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    out_d   = out_q;
    oe_d    = oe_q;
    fs_d    = fs_q;
    if (BCLK_EN) begin
      if (slot_start) begin
        if (empty) begin
          shift_d = LAW ? IdleA : IdleMu;
        end else begin
          shift_d = mem_q[rd_ptr_q];
        end
      end else if (in_slot) begin
        shift_d = {shift_q[6:0], 1'b0};
      end
      oe_d  = in_slot;
      out_d = in_slot && shift_d[7];
      fs_d  = fs_pos;
    end
  end

  // Set events take priority over a coincident clear.
  always_comb begin
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (STAT_CLR) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (slot_start && empty) begin
      underrun_d = 1'b1;
    end
    if (SD_VALID && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q  <= LastPos;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      shift_q    <= 8'h00;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      fs_q       <= fs_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q] <= SD;
      end
    end
  end

  assign PCM_OUT  = out_q;
  assign PCM_OE   = oe_q;
  assign PCM_FS   = fs_q;
  assign UNDERRUN = underrun_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_pcm_tx_serializer.sv
// Bench for pcm_tx_serializer: directed scenarios plus random traffic against a frame-level model.
module tb_pcm_tx_serializer;

  localparam int unsigned Slots = 4;
  localparam int unsigned Slot  = 1;
  localparam int          Fl    = Slots * 8;
  localparam int          Ss    = Slot * 8;

  logic       clk;
  logic       reset;
  logic [7:0] SD;
  logic       SD_VALID;
  logic       SD_READY;
  logic       LAW;
  logic       BCLK_EN;
  logic       STAT_CLR;
  logic       PCM_OUT;
  logic       PCM_OE;
  logic       PCM_FS;
  logic       UNDERRUN;
  logic       OVERFLOW;

  pcm_tx_serializer #(
    .FRAME_SLOTS(Slots),
    .TX_SLOT    (Slot)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .SD       (SD),
    .SD_VALID (SD_VALID),
    .SD_READY (SD_READY),
    .LAW      (LAW),
    .BCLK_EN  (BCLK_EN),
    .STAT_CLR (STAT_CLR),
    .PCM_OUT  (PCM_OUT),
    .PCM_OE   (PCM_OE),
    .PCM_FS   (PCM_FS),
    .UNDERRUN (UNDERRUN),
    .OVERFLOW (OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position, sample queue, byte owning the current slot.
  int         m_pos;
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  logic       m_out, m_oe, m_fs, m_ur, m_ov;
  logic       g_law;
  logic [7:0] cap;
  int         oe_cnt;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b pos=%0d", tag, obs, exp, m_pos);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pos  = Fl - 1;
    m_byte = 8'h00;
    m_out  = 1'b0;
    m_oe   = 1'b0;
    m_fs   = 1'b0;
    m_ur   = 1'b0;
    m_ov   = 1'b0;
  endtask

  task automatic tick(input logic bclk, input logic valid, input logic [7:0] sd, input logic clr);
    logic set_ur, set_ov;
    BCLK_EN  = bclk;
    SD_VALID = valid;
    SD       = sd;
    LAW      = g_law;
    STAT_CLR = clr;
    chk1("ready", SD_READY, m_q.size() < 2);
    @(posedge clk);
    set_ur = 1'b0;
    set_ov = valid && (m_q.size() == 2);
    if (bclk) begin
      m_pos = (m_pos + 1) % Fl;
      if (m_pos == Ss) begin
        if (m_q.size() == 0) begin
          m_byte = g_law ? 8'hD5 : 8'hFF;
          set_ur = 1'b1;
        end else begin
          m_byte = m_q.pop_front();
        end
      end
      m_oe  = (m_pos >= Ss) && (m_pos < Ss + 8);
      m_out = 1'b0;
      if (m_oe) m_out = m_byte[7 - (m_pos - Ss)];
`ifdef PCM_TX_LONG_FS_EN
      m_fs = m_pos < 8;
`else
      m_fs = m_pos == 0;
`endif
    end
    if (valid && !set_ov) m_q.push_back(sd);
    m_ur = set_ur || (m_ur && !clr);
    m_ov = set_ov || (m_ov && !clr);
    @(negedge clk);
    chk1("pcm_out", PCM_OUT, m_out);
    chk1("pcm_oe", PCM_OE, m_oe);
    chk1("pcm_fs", PCM_FS, m_fs);
    chk1("underrun", UNDERRUN, m_ur);
    chk1("overflow", OVERFLOW, m_ov);
    if (bclk && PCM_OE) begin
      cap = {cap[6:0], PCM_OUT};
      oe_cnt++;
    end
  endtask

  // One bit period: the BCLK_EN cycle followed by a random idle gap.
  task automatic bitp(input logic valid, input logic [7:0] sd);
    tick(1'b1, valid, sd, 1'b0);
    repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push(input logic [7:0] sd);
    tick(1'b0, 1'b1, sd, 1'b0);
  endtask

  task automatic run_to(input int p);
    while (m_pos != p) bitp(1'b0, 8'h00);
  endtask

  task automatic frame();
    cap    = 8'h00;
    oe_cnt = 0;
    repeat (Fl) bitp(1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    SD       = 8'h00;
    SD_VALID = 1'b0;
    LAW      = 1'b0;
    BCLK_EN  = 1'b0;
    STAT_CLR = 1'b0;
    g_law    = 1'b0;
    cap      = 8'h00;
    oe_cnt   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk1("rst_out", PCM_OUT, 1'b0);
    chk1("rst_oe", PCM_OE, 1'b0);
    chk1("rst_fs", PCM_FS, 1'b0);
    chk1("rst_ur", UNDERRUN, 1'b0);
    chk1("rst_ov", OVERFLOW, 1'b0);
    chk1("rst_ready", SD_READY, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    // Basic slot
    push(8'hA5);
    frame();
    chk8("basic_byte", cap, 8'hA5);
    chk8("basic_oe_len", 8'(oe_cnt), 8'd8);
    chk1("basic_ur", UNDERRUN, 1'b0);
    chk1("basic_ov", OVERFLOW, 1'b0);

    // Underrun idle codes
    g_law = 1'b1;
    frame();
    chk8("idle_alaw", cap, 8'hD5);
    chk1("idle_ur", UNDERRUN, 1'b1);
    g_law = 1'b0;
    frame();
    chk8("idle_mulaw", cap, 8'hFF);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk1("clr_ur", UNDERRUN, 1'b0);

    // Overflow
    push(8'h11);
    push(8'h22);
    chk1("full_ready", SD_READY, 1'b0);
    push(8'h33);
    chk1("ovf_set", OVERFLOW, 1'b1);
    frame();
    chk8("ovf_first", cap, 8'h11);
    frame();
    chk8("ovf_second", cap, 8'h22);
    tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Push into a full FIFO on the slot-start pop
    push(8'h11);
    push(8'h22);
    cap = 8'h00;
    run_to(Ss - 1);
    bitp(1'b1, 8'h44);
    run_to(Fl - 1);
    chk8("pushpop_sent", cap, 8'h11);
    chk1("pushpop_ov", OVERFLOW, 1'b1);
    frame();
    chk8("pushpop_left", cap, 8'h22);
    chk1("pushpop_ur", UNDERRUN, 1'b0);

    // Push into an empty FIFO on the slot-start pop
    cap = 8'h00;
    run_to(Ss - 1);
    bitp(1'b1, 8'h5A);
    run_to(Fl - 1);
    chk8("emptypush_idle", cap, 8'hFF);
    chk1("emptypush_ur", UNDERRUN, 1'b1);
    frame();
    chk8("emptypush_next", cap, 8'h5A);
    tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset in the middle of the slot
    push(8'h3C);
    push(8'hC3);
    run_to(11);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk1("midrst_oe", PCM_OE, 1'b0);
    chk1("midrst_out", PCM_OUT, 1'b0);
    chk1("midrst_fs", PCM_FS, 1'b0);
    chk1("midrst_ready", SD_READY, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    g_law = 1'b1;
    cap   = 8'h00;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk1("midrst_fs_p0", PCM_FS, 1'b1);
    run_to(Fl - 1);
    chk8("midrst_flushed", cap, 8'hD5);
    chk1("midrst_ur", UNDERRUN, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      g_law = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
           8'($urandom), 1'($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
